// File: rtl/de_stage_pkg.sv
// Shared types for the decode-to-execute stage: control bundle layout and payload shape.
package de_stage_pkg;

    localparam int CTRL_W_DEFAULT = 16;
    localparam int DATA_W_DEFAULT = 32;
    localparam int REG_W_DEFAULT  = 5;

    typedef struct packed {
        logic [1:0] pad;
        logic [2:0] branch_mode;
        logic       alu_src;
        logic [3:0] alu_control;
        logic       branch;
        logic       jump;
        logic       mem_write;
        logic [1:0] result_src;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        ctrl_t                     ctrl;
        logic [DATA_W_DEFAULT-1:0] rd1;
        logic [DATA_W_DEFAULT-1:0] rd2;
        logic [DATA_W_DEFAULT-1:0] pc;
        logic [DATA_W_DEFAULT-1:0] pc4;
        logic [DATA_W_DEFAULT-1:0] imm;
        logic [REG_W_DEFAULT-1:0]  rs1;
        logic [REG_W_DEFAULT-1:0]  rs2;
        logic [REG_W_DEFAULT-1:0]  rd;
    } payload_t;

    // Flat payload width; field order matches payload_t.
    function automatic int payload_width(input int dw, input int aw, input int cw);
        return cw + 5 * dw + 3 * aw;
    endfunction

endpackage

// File: rtl/de_stage_entry.sv
// One payload register of the stage: load enable with a synchronous clear.
module de_stage_entry #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] payload_d;
    logic [WIDTH-1:0] payload_q;

    always_comb begin
        payload_d = payload_q;
        if (clr) begin
            payload_d = '0;
        end else if (load) begin
            payload_d = d;
        end
    end

    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

    assign q = payload_q;

endmodule

// File: rtl/de_stage_skid.sv
// Decode-to-execute stage with a 2-entry skid buffer, registered ready and flush.
module de_stage_skid
    import de_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      d_valid,
    output logic                      d_ready,
    input  logic [CTRL_WIDTH-1:0]     d_ctrl,
    input  logic [DATA_WIDTH-1:0]     d_rd1,
    input  logic [DATA_WIDTH-1:0]     d_rd2,
    input  logic [DATA_WIDTH-1:0]     d_pc,
    input  logic [DATA_WIDTH-1:0]     d_pc4,
    input  logic [DATA_WIDTH-1:0]     d_imm,
    input  logic [REG_ADDR_WIDTH-1:0] d_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] d_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] d_rd,
    output logic                      e_valid,
    input  logic                      e_ready,
    output logic [CTRL_WIDTH-1:0]     e_ctrl,
    output logic [DATA_WIDTH-1:0]     e_rd1,
    output logic [DATA_WIDTH-1:0]     e_rd2,
    output logic [DATA_WIDTH-1:0]     e_pc,
    output logic [DATA_WIDTH-1:0]     e_pc4,
    output logic [DATA_WIDTH-1:0]     e_imm,
    output logic [REG_ADDR_WIDTH-1:0] e_rs1,
    output logic [REG_ADDR_WIDTH-1:0] e_rs2,
    output logic [REG_ADDR_WIDTH-1:0] e_rd,
    output logic [1:0]                occupancy
);

    localparam int PW = payload_width(DATA_WIDTH, REG_ADDR_WIDTH, CTRL_WIDTH);

    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          main_load, skid_load, main_from_skid;
    logic          accept, drain, clr;
    logic [PW-1:0] in_pl, main_pl_d, main_pl_q, skid_pl_q;
    logic [CTRL_WIDTH-1:0] main_ctrl;

    assign in_pl   = {d_ctrl, d_rd1, d_rd2, d_pc, d_pc4, d_imm, d_rs1, d_rs2, d_rd};
    assign d_ready = !skid_valid_q;
    assign accept  = d_valid && d_ready;
    assign drain   = main_valid_q && e_ready;
    assign clr     = !rst_n;

    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            // Skid is always older than the input, so it moves up first.
            if (skid_valid_q) begin
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                main_valid_d   = 1'b1;
                skid_load      = accept;
                skid_valid_d   = accept;
            end else begin
                main_load    = accept;
                main_valid_d = accept;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
        main_pl_d = main_from_skid ? skid_pl_q : in_pl;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    de_stage_entry #(.WIDTH(PW)) u_main (
        .clk  (clk),
        .clr  (clr),
        .load (main_load),
        .d    (main_pl_d),
        .q    (main_pl_q)
    );

    de_stage_entry #(.WIDTH(PW)) u_skid (
        .clk  (clk),
        .clr  (clr),
        .load (skid_load),
        .d    (in_pl),
        .q    (skid_pl_q)
    );

    assign {main_ctrl, e_rd1, e_rd2, e_pc, e_pc4, e_imm, e_rs1, e_rs2, e_rd} = main_pl_q;
    assign e_valid   = main_valid_q;
    assign e_ctrl    = main_valid_q ? main_ctrl : '0;
    assign occupancy = 2'(main_valid_q) + 2'(skid_valid_q);

endmodule
